exec_sequencer: RTL and testbench

Multi-cycle controller that sequences one instruction at a time through the register-file read, ALU execute and register-file write-back steps of the decode/execute datapath. It accepts 32-bit instructions over a valid/ready handshake and drives the regfile read/write ports and the ALU operand/opcode inputs. It captures the ALU result and presents it on a result handshake. It sits between the instruction source and the existing `regfile` and `alu` instances, replacing the hard-wired, always-writing connections.

---
 rtl/exec_pkg.sv | 31 +++
 rtl/instr_fields.sv | 35 +++
 rtl/exec_sequencer.sv | 150 +++++++++++++++
 tb/tb_exec_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types and constants for the exec_sequencer controller and its decode helper.
// Covers the FSM state encoding, opcode values and instruction field positions.
package exec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WB,
        DONE
    } state_t;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int F7_LSB  = 25;
    localparam int F7_MSB  = 31;
    localparam int IMM_LSB = 20;
    localparam int IMM_MSB = 31;

    localparam int ALU_OP_W = 14;

endpackage

// File: rtl/instr_fields.sv
// Combinational field extraction, legality check and I-type immediate sign-extension.
// Purely combinational so later decode stages can reuse it as-is.
module instr_fields
    import exec_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [31:0]         instr,
    output logic [6:0]          opc,
    output logic [4:0]          rd,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [6:0]          funct7,
    output logic                legal,
    output logic                is_itype,
    output logic signed [N-1:0] imm
);

    logic signed [IMM_MSB-IMM_LSB:0] imm12;
    // funct3 has no meaning on this datapath; the ALU decodes {funct7, opcode} only
    logic unused_funct3;

    assign opc      = instr[OPC_MSB:OPC_LSB];
    assign rd       = instr[RD_MSB:RD_LSB];
    assign rs1      = instr[RS1_MSB:RS1_LSB];
    assign rs2      = instr[RS2_MSB:RS2_LSB];
    assign funct7   = instr[F7_MSB:F7_LSB];
    assign imm12    = instr[IMM_MSB:IMM_LSB];
    assign imm      = N'(imm12);
    assign is_itype = (opc == OPC_ITYPE);
    assign legal    = (opc == OPC_RTYPE) || is_itype;

    assign unused_funct3 = ^instr[14:12];

endmodule

// File: rtl/exec_sequencer.sv
// One-instruction-at-a-time controller: regfile read, ALU execute, regfile write-back,
// then a result handshake. Drives the existing regfile and alu instances.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [31:0]         instr,
    output logic [4:0]          rf_raddr_a,
    output logic [4:0]          rf_raddr_b,
    input  logic [N-1:0]        rf_rdata_a,
    input  logic [N-1:0]        rf_rdata_b,
    output logic [N-1:0]        alu_a,
    output logic [N-1:0]        alu_b,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [N-1:0]        alu_result,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [N-1:0]        rf_wdata,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [N-1:0]        res_data,
    output logic                res_illegal,
    output logic [31:0]         retired
);

    state_t state, state_next;

    logic [31:0]         ir;
    logic [31:0]         dec_src;
    logic                take;
    logic                accept;
    logic [6:0]          opc;
    logic [6:0]          funct7;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                legal;
    logic                is_itype;
    logic signed [N-1:0] imm;

    // While accepting, decode the incoming word; otherwise decode the latched one
    assign take        = (state == IDLE) || ((state == DONE) && res_ready);
    assign instr_ready = take;
    assign dec_src     = take ? instr : ir;

    instr_fields #(.N(N)) u_fields (
        .instr    (dec_src),
        .opc      (opc),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct7   (funct7),
        .legal    (legal),
        .is_itype (is_itype),
        .imm      (imm)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        rf_we      = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    accept     = 1'b1;
                    state_next = legal ? READ : DONE;
                end
            end
            READ: state_next = EXEC;
            EXEC: state_next = WB;
            WB: begin
                rf_we      = (rd != 5'd0);
                state_next = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    if (instr_valid) begin
                        accept     = 1'b1;
                        state_next = legal ? READ : DONE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir          <= '0;
            rf_raddr_a  <= '0;
            rf_raddr_b  <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            res_data    <= '0;
            res_illegal <= 1'b0;
            retired     <= '0;
        end else begin
            // accept -> READ: latch word and read addresses
            if (accept) begin
                ir          <= instr;
                res_illegal <= !legal;
                if (legal) begin
                    rf_raddr_a <= rs1;
                    rf_raddr_b <= rs2;
                end else begin
                    res_data <= '0;
                end
            end
            // READ -> EXEC: capture operands
            if (state == READ) begin
                alu_a  <= rf_rdata_a;
                alu_b  <= is_itype ? $unsigned(imm) : rf_rdata_b;
                alu_op <= {(is_itype ? 7'b0 : funct7), opc};
            end
            // EXEC -> WB: rf_wdata doubles as the result register
            if (state == EXEC) begin
                rf_waddr <= rd;
                rf_wdata <= alu_result;
            end
            // WB -> DONE: publish result
            if (state == WB) begin
                res_data <= rf_wdata;
            end
            if ((state == DONE) && res_ready && !res_illegal) begin
                retired <= retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed literal checks plus randomized traffic compared
// every cycle against a transaction-level model with its own shadow register file.
module tb_exec_sequencer;

    localparam int N = 32;

    logic          clk;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [4:0]    rf_raddr_a;
    logic [4:0]    rf_raddr_b;
    logic [N-1:0]  rf_rdata_a;
    logic [N-1:0]  rf_rdata_b;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [13:0]   alu_op;
    logic [N-1:0]  alu_result;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [N-1:0]  rf_wdata;
    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  res_data;
    logic          res_illegal;
    logic [31:0]   retired;

    logic [N-1:0]  env_rf [32];
    logic          preload;
    int            total = 0;
    int            bad = 0;

    exec_sequencer #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_rdata_a  (rf_rdata_a),
        .rf_rdata_b  (rf_rdata_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_illegal (res_illegal),
        .retired     (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment: combinational-read regfile and an add/sub ALU
    assign rf_rdata_a = env_rf[rf_raddr_a];
    assign rf_rdata_b = env_rf[rf_raddr_b];
    assign alu_result = (alu_op[13:7] == 7'h20) ? alu_a - alu_b : alu_a + alu_b;

    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'd0;
        if (i == 1) return 32'd5;
        if (i == 2) return 32'd7;
        return 32'(i) * 32'h01010101 + 32'h3;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) env_rf[i] <= init_val(i);
        end else if (rf_we && rf_waddr != 5'd0) begin
            env_rf[rf_waddr] <= rf_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model state
    logic [31:0] shadow [32];
    bit          m_busy;
    int          m_age;
    bit          m_legal;
    bit          m_ill;
    logic [4:0]  m_rd;
    logic [31:0] m_a, m_b, m_res, m_ret;
    logic [13:0] m_op;
    logic [4:0]  h_ra, h_rb, h_wa;
    logic [31:0] h_a, h_b, h_wd, h_res;
    logic [13:0] h_op;

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_legal = 0; m_ill = 0; m_ret = 0;
        h_ra = 0; h_rb = 0; h_wa = 0; h_a = 0; h_b = 0; h_wd = 0; h_res = 0; h_op = 0;
    endtask

    initial begin : compare
        bit          done_now, exp_ready, exp_we, acc;
        logic [6:0]  opc, f7;
        logic [4:0]  rs1, rs2;
        for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
        model_reset();
        @(posedge clk);
        forever begin
            @(negedge clk);
            done_now  = m_busy && (m_legal ? (m_age >= 4) : (m_age >= 1));
            exp_ready = !m_busy || (done_now && res_ready);
            exp_we    = m_busy && m_legal && (m_age == 3) && (m_rd != 5'd0);
            chk("instr_ready", instr_ready, exp_ready);
            chk("rf_we", rf_we, exp_we);
            chk("res_valid", res_valid, done_now);
            chk("retired", retired, m_ret);
            chk("rf_raddr_a", rf_raddr_a, h_ra);
            chk("rf_raddr_b", rf_raddr_b, h_rb);
            chk("alu_a", alu_a, h_a);
            chk("alu_b", alu_b, h_b);
            chk("alu_op", alu_op, h_op);
            chk("rf_waddr", rf_waddr, h_wa);
            chk("rf_wdata", rf_wdata, h_wd);
            if (done_now) begin
                chk("res_data", res_data, h_res);
                chk("res_illegal", res_illegal, m_ill);
            end
            // Predict the effect of the coming rising edge
            if (!rst_n) begin
                model_reset();
            end else begin
                acc = instr_valid && exp_ready;
                if (done_now && res_ready) begin
                    if (m_legal) m_ret = m_ret + 1;
                    m_busy = 0;
                end else if (m_busy) begin
                    m_age++;
                    if (m_legal && m_age == 2) begin h_a = m_a; h_b = m_b; h_op = m_op; end
                    if (m_legal && m_age == 3) begin
                        h_wa = m_rd; h_wd = m_res;
                        if (m_rd != 5'd0) shadow[m_rd] = m_res;
                    end
                    if (m_legal && m_age == 4) h_res = m_res;
                end
                if (acc) begin
                    opc = instr[6:0]; m_rd = instr[11:7]; rs1 = instr[19:15];
                    rs2 = instr[24:20]; f7 = instr[31:25];
                    m_busy = 1; m_age = 1;
                    m_legal = (opc == 7'h33) || (opc == 7'h13);
                    m_ill = !m_legal;
                    if (m_legal) begin
                        h_ra = rs1; h_rb = rs2;
                        m_a = shadow[rs1];
                        if (opc == 7'h33) begin
                            m_b = shadow[rs2];
                            m_op = {f7, opc};
                            m_res = (f7 == 7'h20) ? m_a - m_b : m_a + m_b;
                        end else begin
                            m_b = 32'($signed(instr[31:20]));
                            m_op = {7'b0, opc};
                            m_res = m_a + m_b;
                        end
                    end else begin
                        h_res = 32'd0;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        int          kind;
        logic [31:0] w;
        kind = $urandom_range(0, 9);
        w = $urandom;
        if (kind < 4) begin
            w[6:0] = 7'h33;
            if (kind == 0) w[31:25] = 7'h20;
            else if (kind == 1) w[31:25] = 7'h00;
        end else if (kind < 8) begin
            w[6:0] = 7'h13;
        end else if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            w[2] = ~w[2];
        end
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        rst_n = 1'b0; preload = 1'b1; instr_valid = 1'b0; instr = '0; res_ready = 1'b0;
        cyc(); preload = 1'b0;
        cyc();

        // R-type add x3,x1,x2 with x1=5, x2=7
        rst_n = 1'b1; instr_valid = 1'b1; instr = 32'h002081B3;
        @(negedge clk);
        chk("rst_retired", retired, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("idle_ready", instr_ready, 1);
        cyc(); instr_valid = 1'b0;
        @(negedge clk);
        chk("add_raddr_a", rf_raddr_a, 1);
        chk("add_raddr_b", rf_raddr_b, 2);
        cyc();
        @(negedge clk);
        chk("add_alu_a", alu_a, 5);
        chk("add_alu_b", alu_b, 7);
        cyc();
        @(negedge clk);
        chk("add_we", rf_we, 1);
        chk("add_waddr", rf_waddr, 3);
        chk("add_wdata", rf_wdata, 12);
        cyc(); res_ready = 1'b1;
        @(negedge clk);
        chk("add_we_off", rf_we, 0);
        chk("add_valid", res_valid, 1);
        chk("add_res", res_data, 12);
        cyc(); res_ready = 1'b0;
        @(negedge clk);
        chk("add_retired", retired, 1);

        // addi x4,x1,-1
        cyc(); instr_valid = 1'b1; instr = 32'hFFF08213;
        cyc(); instr_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("addi_alu_b", alu_b, 32'hFFFFFFFF);
        chk("addi_alu_op", alu_op, 14'h0013);
        cyc();
        @(negedge clk);
        chk("addi_waddr", rf_waddr, 4);
        chk("addi_wdata", rf_wdata, 4);
        cyc(); res_ready = 1'b1;
        cyc(); res_ready = 1'b0;
        @(negedge clk);
        chk("addi_retired", retired, 2);

        // Illegal opcode 7'b1111111
        cyc(); instr_valid = 1'b1; instr = 32'h0000007F;
        cyc(); instr_valid = 1'b0;
        @(negedge clk);
        chk("ill_valid", res_valid, 1);
        chk("ill_flag", res_illegal, 1);
        chk("ill_data", res_data, 0);
        chk("ill_we", rf_we, 0);
        cyc(); res_ready = 1'b1;
        cyc(); res_ready = 1'b0;
        @(negedge clk);
        chk("ill_retired", retired, 2);

        // add x0,x1,x2: write suppressed, still retired
        cyc(); instr_valid = 1'b1; instr = 32'h00208033;
        cyc(); instr_valid = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rd0_we", rf_we, 0);
        cyc(); res_ready = 1'b1;
        @(negedge clk);
        chk("rd0_valid", res_valid, 1);
        cyc(); res_ready = 1'b0;
        @(negedge clk);
        chk("rd0_retired", retired, 3);

        // sub x5,x2,x1 = 2, then backpressure and back-to-back addi x6,x0,5
        cyc(); instr_valid = 1'b1; instr = 32'h401102B3;
        cyc(); instr_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_res", res_data, 2);
            chk("bp_ready", instr_ready, 0);
            cyc();
        end
        res_ready = 1'b1; instr_valid = 1'b1; instr = 32'h00500313;
        @(negedge clk);
        chk("b2b_ready", instr_ready, 1);
        cyc(); instr_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        chk("b2b_raddr_a", rf_raddr_a, 0);
        chk("b2b_retired", retired, 4);
        chk("b2b_valid", res_valid, 0);
        cyc();
        cyc();
        @(negedge clk);
        chk("b2b_waddr", rf_waddr, 6);
        chk("b2b_wdata", rf_wdata, 5);
        cyc(); res_ready = 1'b1;
        cyc(); res_ready = 1'b0;
        @(negedge clk);
        chk("b2b_retired2", retired, 5);

        // Reset while in WB
        cyc(); instr_valid = 1'b1; instr = 32'h002083B3;
        cyc(); instr_valid = 1'b0;
        cyc();
        cyc(); rst_n = 1'b0;
        @(negedge clk);
        chk("wbrst_we_before", rf_we, 1);
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        chk("wbrst_we", rf_we, 0);
        chk("wbrst_valid", res_valid, 0);
        chk("wbrst_retired", retired, 0);
        chk("wbrst_ready", instr_ready, 1);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            cyc();
            rst_n       = ($urandom_range(0, 299) != 0);
            instr_valid = ($urandom_range(0, 2) != 0);
            instr       = rand_instr();
            res_ready   = ($urandom_range(0, 3) != 0);
        end
        cyc(); rst_n = 1'b1; instr_valid = 1'b0; res_ready = 1'b1;
        repeat (8) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
